// File: rtl/irq_sender_pkg.sv
// Shared definitions for the bus interrupt transmitter: FSM state codes,
// interrupt-word bit positions (big-endian [0:15] numbering) and the word encoder.
package irq_sender_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARB     = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_STROBE  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_BACKOFF = 3'd5;

  localparam int RDT_CPU     = 15;
  localparam int RDT_LOW     = 0;
  localparam int RDT_CHAN_HI = 11;
  localparam int RDT_CHAN_LO = 14;

  typedef struct packed {
    logic cpu;
    logic low;
  } irq_ent_t;

  function automatic logic [0:15] irq_word(input irq_ent_t e, input logic [3:0] chan);
    logic [0:15] w;
    w = '0;
    if (e.cpu) begin
      w[RDT_CPU] = 1'b1;
      w[RDT_LOW] = e.low;
    end else begin
      w[RDT_CHAN_HI:RDT_CHAN_LO] = chan;
    end
    return w;
  endfunction

endpackage

// File: rtl/irq_sender_fifo.sv
// Synchronous request FIFO; power-of-two depth, occupancy count drives full/empty.
module irq_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/irq_sender.sv
// Bus interrupt transmitter: queues requests, arbitrates for the bus, strobes rin/rdt
// and completes a 4-phase handshake on dok, retrying after backoff on timeout or lost grant.
module irq_sender
  import irq_sender_pkg::*;
#(
  parameter logic [3:0] CHAN_NUM    = 4'd0,
  parameter int         DEPTH       = 4,
  parameter int         RESP_TICKS  = 16,
  parameter int         RETRY_TICKS = 32
) (
  input  logic                   __clk,
  input  logic                   clm_,
  input  logic                   req,
  input  logic                   req_cpu,
  input  logic                   req_low,
  output logic                   full,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   dropped,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic                   rin,
  output logic [0:15]            rdt,
  input  logic                   dok
);
  localparam int TMAX = (RESP_TICKS > RETRY_TICKS) ? RESP_TICKS : RETRY_TICKS;
  localparam int TW   = $clog2(TMAX) + 1;

  logic [2:0]    state, nxt;
  logic [TW-1:0] timer;
  logic [1:0]    dok_pipe;
  logic          dok_s, empty, deq;
  logic [1:0]    fifo_q;
  irq_ent_t      head;
  logic [0:15]   word_q;

  assign dok_s = dok_pipe[1];
  assign head  = fifo_q;

  irq_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_fifo (
    .clk     (__clk),
    .rst_n   (clm_),
    .wr_en   (req),
    .wr_data ({req_cpu, req_low}),
    .rd_en   (deq),
    .rd_data (fifo_q),
    .count   (pending),
    .full    (full),
    .empty   (empty)
  );

  // dok wins over both timeout and a dropped grant: the receiver already took the word.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (!empty) nxt = ST_ARB;
      ST_ARB:     if (bus_gnt && !dok_s) nxt = ST_SETUP;
      ST_SETUP:   nxt = bus_gnt ? ST_STROBE : ST_BACKOFF;
      ST_STROBE: begin
        if (dok_s) nxt = ST_RELEASE;
        else if (!bus_gnt || timer == TW'(RESP_TICKS - 1)) nxt = ST_BACKOFF;
      end
      ST_RELEASE: if (!dok_s) nxt = ST_IDLE;
      ST_BACKOFF: if (timer == TW'(RETRY_TICKS - 1)) nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  assign deq = (state == ST_STROBE) && (nxt == ST_RELEASE);

  always_ff @(posedge __clk or negedge clm_) begin
    if (!clm_) begin
      state    <= ST_IDLE;
      timer    <= '0;
      dok_pipe <= '0;
      word_q   <= '0;
      dropped  <= 1'b0;
    end else begin
      state    <= nxt;
      dok_pipe <= {dok_pipe[0], dok};
      dropped  <= dropped | (req & full);
      if (nxt == state && (state == ST_STROBE || state == ST_BACKOFF))
        timer <= timer + TW'(1);
      else
        timer <= '0;
      // Latch the word so it survives the dequeue on entry to RELEASE.
      if (state == ST_ARB && nxt == ST_SETUP)
        word_q <= irq_word(head, CHAN_NUM);
    end
  end

  assign rin     = (state == ST_STROBE);
  assign bus_req = (state == ST_ARB) || (state == ST_SETUP) ||
                   (state == ST_STROBE) || (state == ST_RELEASE);
  assign rdt     = ((state == ST_SETUP) || (state == ST_STROBE) || (state == ST_RELEASE))
                   ? word_q : '0;

endmodule
